carbon_sim_ctl: RTL and testbench

CARBON_SIM_CTL -- requirements
Module: carbon_sim_ctl

---
 rtl/carbon_simctl_pkg.sv | 28 ++
 rtl/carbon_sim_ctl.sv | 154 +++++++++++++++
 tb/tb_carbon_sim_ctl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/carbon_simctl_pkg.sv
// Shared definitions for carbon_sim_ctl: register offsets, power states and defaults.
package carbon_simctl_pkg;

  localparam logic [7:0]  ADDR_SIG   = 8'h00;
  localparam logic [7:0]  ADDR_CTRL  = 8'h04;
  localparam logic [7:0]  ADDR_ID    = 8'h08;
  localparam logic [7:0]  ADDR_CYCLE = 8'h0C;

  localparam logic [31:0] DEFAULT_POWEROFF_KEY = 32'h5AFE_0FF0;
  localparam logic [31:0] DEFAULT_ID_VALUE     = 32'h4353_494D;

  typedef enum logic [1:0] {
    PWR_RUN   = 2'd0,
    PWR_DRAIN = 2'd1,
    PWR_OFF   = 2'd2
  } pwr_state_e;

  function automatic logic [31:0] merge_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/carbon_sim_ctl.sv
// Simulation control block: signature register, keyed drain-then-poweroff FSM.
// Optional 64-bit cycle counter at 0x0C when CARBON_SIMCTL_CYCLECOUNT_EN is defined.
module carbon_sim_ctl
  import carbon_simctl_pkg::*;
#(
  parameter logic [31:0] POWEROFF_KEY = DEFAULT_POWEROFF_KEY,
  parameter int unsigned DRAIN_CYCLES = 16,
  parameter logic [31:0] ID_VALUE     = DEFAULT_ID_VALUE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] signature,
  output logic        poweroff
);

  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES);

  pwr_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] sig_q, sig_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        poweroff_q;
  logic        accept_s;
  logic [7:0]  word_s;

`ifdef CARBON_SIMCTL_CYCLECOUNT_EN
  logic [63:0] cycle_q;
  logic        cycle_hi_unused_s;
  assign cycle_hi_unused_s = ^cycle_q[63:32];

  // Free-running counter, held once the power FSM reaches OFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= 64'd0;
    end else if (state_q != PWR_OFF) begin
      cycle_q <= cycle_q + 64'd1;
    end else begin
      cycle_q <= cycle_q;
    end
  end
`endif

  assign accept_s  = req_valid && !rsp_valid_q;
  assign word_s    = req_addr & 8'hFC;
  assign req_ready = !rsp_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign signature = sig_q;
  assign poweroff  = poweroff_q;

  // Next-state for power FSM, signature and response holding registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sig_d       = sig_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    // OFF is entered on the edge where the counter reaches zero.
    if (state_q == PWR_DRAIN) begin
      if (cnt_q <= 8'd1) begin
        cnt_d   = 8'd0;
        state_d = PWR_OFF;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end

    if (accept_s) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = 32'd0;
      rsp_err_d   = 1'b0;
      if (req_write) begin
        if (state_q == PWR_OFF) begin
          rsp_err_d = 1'b1;
        end else begin
          case (word_s)
            ADDR_SIG:  sig_d = merge_wstrb(sig_q, req_wdata, req_wstrb);
            ADDR_CTRL: begin
              // A repeated key while draining is accepted but must not restart the count.
              if ((req_wstrb == 4'hF) && (req_wdata == POWEROFF_KEY)) begin
                if (state_q == PWR_RUN) begin
                  state_d = PWR_DRAIN;
                  cnt_d   = DRAIN_LOAD;
                end else begin
                  state_d = state_d;
                end
              end else begin
                rsp_err_d = 1'b1;
              end
            end
            default:   rsp_err_d = 1'b1;
          endcase
        end
      end else begin
        case (word_s)
          ADDR_SIG:   rsp_rdata_d = sig_q;
          ADDR_CTRL:  rsp_rdata_d = {30'd0, state_q == PWR_OFF, state_q == PWR_DRAIN};
          ADDR_ID:    rsp_rdata_d = ID_VALUE;
`ifdef CARBON_SIMCTL_CYCLECOUNT_EN
          ADDR_CYCLE: rsp_rdata_d = cycle_q[31:0];
`endif
          default:    rsp_err_d   = 1'b1;
        endcase
      end
    end else begin
      rsp_rdata_d = rsp_rdata_q;
    end
  end

  // State and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWR_RUN;
      cnt_q       <= 8'd0;
      sig_q       <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      poweroff_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sig_q       <= sig_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      poweroff_q  <= (state_d == PWR_OFF);
    end
  end

endmodule

// File: tb/tb_carbon_sim_ctl.sv
// Randomized scoreboard bench for carbon_sim_ctl against a cycle-indexed reference model.
module tb_carbon_sim_ctl;

  localparam logic [31:0] KEY   = 32'h5AFE_0FF0;
  localparam int          DRAIN = 16;
  localparam logic [31:0] IDV   = 32'h4353_494D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = 8'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wstrb = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] signature;
  logic        poweroff;

  carbon_sim_ctl #(
    .POWEROFF_KEY (KEY),
    .DRAIN_CYCLES (DRAIN),
    .ID_VALUE     (IDV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .signature (signature),
    .poweroff  (poweroff)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_data;
    logic [31:0] sig;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  longint      edge_cnt = 0;
  logic [31:0] sig_m = 32'd0;
  bit          key_seen = 1'b0;
  longint      off_at = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    sig_m    = 32'd0;
    key_seen = 1'b0;
    off_at   = 0;
    sb_q.delete();
  endtask

  // Reference model: state at an accepting edge follows from when the key was accepted.
  task automatic model_req(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input longint e_edge, output exp_t ex);
    bit         was_off;
    bit         was_drain;
    logic [7:0] word;
    was_off   = key_seen && (e_edge - 1 >= off_at);
    was_drain = key_seen && !was_off;
    word      = addr & 8'hFC;
    ex.rdata    = 32'd0;
    ex.err      = 1'b0;
    ex.chk_data = 1'b1;
    if (wr) begin
      if (was_off) ex.err = 1'b1;
      else if (word == 8'h00) begin
        for (int b = 0; b < 4; b++) if (ws[b]) sig_m[8*b +: 8] = wd[8*b +: 8];
      end else if (word == 8'h04 && ws == 4'hF && wd == KEY) begin
        if (!key_seen) begin
          key_seen = 1'b1;
          off_at   = e_edge + DRAIN;
        end
      end else ex.err = 1'b1;
    end else begin
      case (word)
        8'h00:   ex.rdata = sig_m;
        8'h04:   ex.rdata = {30'd0, was_off, was_drain};
        8'h08:   ex.rdata = IDV;
`ifdef CARBON_SIMCTL_CYCLECOUNT_EN
        8'h0C:   ex.chk_data = 1'b0;
`endif
        default: ex.err = 1'b1;
      endcase
    end
    ex.sig = sig_m;
  endtask

  // Issue one request (called at a negedge) and complete its handshake after `hold` stalls.
  task automatic do_req(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input int hold);
    exp_t ex;
    int   guard;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = ws;
    rsp_ready = (hold == 0);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_ready_timeout: got 0 expected 1 within 20 cycles");
      req_valid = 1'b0;
      return;
    end
    model_req(wr, addr, wd, ws, edge_cnt + 1, ex);
    sb_q.push_back(ex);
    @(negedge clk);
    req_valid = 1'b0;
    check("rsp_valid_after_accept", 32'(rsp_valid), 32'd1);
    check("req_ready_after_accept", 32'(req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("req_ready_hold", 32'(req_ready), 32'd0);
      check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("req_ready_after_hs", 32'(req_ready), 32'd1);
    check("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
  endtask

  task automatic wait_edge(input longint target);
    while (edge_cnt + 1 < target) @(negedge clk);
  endtask

  task automatic rand_phase(input int n, input bit allow_key);
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [3:0]  ws;
    bit          wr;
    int          sel;
    for (int i = 0; i < n; i++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3: addr = 8'h00;
        4, 5:       addr = 8'h04;
        6:          addr = 8'h08;
        7:          addr = 8'h0C;
        default:    addr = 8'($urandom_range(16, 255));
      endcase
      addr = addr | 8'($urandom_range(0, 3));
      wr   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      ws   = 4'($urandom_range(0, 15));
      if (allow_key && wr && (addr & 8'hFC) == 8'h04 && $urandom_range(0, 3) == 0) begin
        wd = KEY;
        ws = 4'hF;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(wr, addr, wd, ws, int'($urandom_range(0, 3)));
    end
  endtask

  // Scoreboard monitor: pops on every response handshake, checks stability while stalled.
  always begin : monitor
    exp_t        e;
    logic        prev_valid;
    logic        prev_hs;
    logic [31:0] prev_rdata;
    logic        prev_err;
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    prev_rdata = 32'd0;
    prev_err   = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (rsp_valid && prev_valid && !prev_hs) begin
          check("rsp_rdata_stable", rsp_rdata, prev_rdata);
          check("rsp_err_stable", 32'(rsp_err), 32'(prev_err));
        end
        if (rsp_valid && rsp_ready) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got response with empty scoreboard");
          end else begin
            e = sb_q.pop_front();
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            if (e.chk_data) check("rsp_rdata", rsp_rdata, e.rdata);
            check("signature", signature, e.sig);
          end
        end
        prev_valid = rsp_valid;
        prev_hs    = rsp_valid && rsp_ready;
        prev_rdata = rsp_rdata;
        prev_err   = rsp_err;
      end
    end
  end

  // poweroff must rise exactly DRAIN edges after the first accepted key.
  always begin : pwr_mon
    @(negedge clk);
    #1;
    if (rst_n) check("poweroff", 32'(poweroff), 32'(key_seen && edge_cnt >= off_at));
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_signature"}, signature, 32'd0);
    check({tag, "_poweroff"}, 32'(poweroff), 32'd0);
  endtask

  initial begin : stim
    longint n_key;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(1'b1, 8'h00, 32'h2136_3958, 4'hF, 0);
    do_req(1'b0, 8'h00, 32'd0, 4'h0, 0);
    check("sig_full_write", signature, 32'h2136_3958);
    do_req(1'b1, 8'h00, 32'hAABB_CCDD, 4'b0101, 0);
    check("sig_lane_write", signature, 32'h21BB_39DD);
    do_req(1'b1, 8'h00, 32'hFFFF_FFFF, 4'h0, 1);
    do_req(1'b1, 8'h04, 32'h1234_5678, 4'hF, 0);
    do_req(1'b0, 8'h04, 32'd0, 4'h0, 0);
    do_req(1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, 0);
    do_req(1'b1, 8'h08, 32'h0000_0001, 4'hF, 0);
    do_req(1'b0, 8'h0B, 32'd0, 4'h0, 0);
    do_req(1'b0, 8'h0C, 32'd0, 4'h0, 0);
    do_req(1'b1, 8'h04, KEY, 4'h7, 0);
    do_req(1'b0, 8'h00, 32'd0, 4'h0, 5);

    rand_phase(60, 1'b0);

    n_key = edge_cnt + 1;
    do_req(1'b1, 8'h04, KEY, 4'hF, 0);
    wait_edge(n_key + 5);
    do_req(1'b0, 8'h04, 32'd0, 4'h0, 0);
    do_req(1'b1, 8'h04, KEY, 4'hF, 0);
    do_req(1'b1, 8'h00, 32'h0BAD_F00D, 4'hC, 1);
    wait_edge(n_key + 20);
    check("poweroff_after_drain", 32'(poweroff), 32'd1);
    do_req(1'b1, 8'h00, 32'd0, 4'hF, 0);
    do_req(1'b0, 8'h04, 32'd0, 4'h0, 0);
    rand_phase(40, 1'b1);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset_off");
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(1'b0, 8'h00, 32'd0, 4'h0, 0);

    do_req(1'b1, 8'h04, KEY, 4'hF, 0);
    repeat (3) @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h00;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("pending_before_reset", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset_drain");
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    do_req(1'b0, 8'h04, 32'd0, 4'h0, 0);

    rand_phase(150, 1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
